// File: rtl/tt_sweep_pkg.sv
// rtl/tt_sweep_pkg.sv - shared constants and FSM encoding for the truth-table sweep checker
package tt_sweep_pkg;

  localparam int DEF_N_IN       = 3;
  localparam int DEF_SETTLE_CYC = 1;

  function automatic int n_vec(input int n_in);
    return 1 << n_in;
  endfunction

  localparam int N_VEC = n_vec(DEF_N_IN);

  localparam logic [1:0] ST_IDLE        = 2'd0;
  localparam logic [1:0] ST_HOLD        = 2'd1;
  localparam logic [1:0] ST_SAMPLE_LAST = 2'd2;

endpackage

// File: rtl/tt_sweep_checker_if.sv
// rtl/tt_sweep_checker_if.sv - control, stimulus and result bundle of the sweep checker
interface tt_sweep_checker_if
  import tt_sweep_pkg::*;
#(
  parameter int N_IN = DEF_N_IN
);
  localparam int NV = n_vec(N_IN);

  logic            start;
  logic            abort;
  logic [NV-1:0]   exp_tt;
  logic            f;
  logic [N_IN-1:0] vec;
  logic            busy;
  logic            done;
  logic            pass;
  logic [N_IN:0]   err_cnt;
  logic            fail_valid;
  logic [N_IN-1:0] fail_idx;
  logic [NV-1:0]   obs_tt;

  modport master (
    output start, abort, exp_tt, f,
    input  vec, busy, done, pass, err_cnt, fail_valid, fail_idx, obs_tt
  );

  modport slave (
    input  start, abort, exp_tt, f,
    output vec, busy, done, pass, err_cnt, fail_valid, fail_idx, obs_tt
  );

endinterface

// File: rtl/tt_sweep_checker_settle_timer.sv
// rtl/tt_sweep_checker_settle_timer.sv - loadable down-counter timing each vector's settle window
module settle_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] value,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign value = cnt;
  assign zero  = (cnt == '0);

endmodule

// File: rtl/tt_sweep_checker.sv
// rtl/tt_sweep_checker.sv - walks all input vectors, samples f and compares against an expected truth table
module tt_sweep_checker
  import tt_sweep_pkg::*;
#(
  parameter int N_IN       = DEF_N_IN,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
  input  logic               clk,
  input  logic               rst_n,
  tt_sweep_checker_if.slave  bus
);

  localparam int NV = n_vec(N_IN);
  localparam int CW = (SETTLE_CYC > 0) ? $clog2(SETTLE_CYC + 1) : 1;
  localparam logic [N_IN-1:0] LAST_VEC = N_IN'(NV - 1);
  localparam logic [N_IN-1:0] PRE_LAST = N_IN'(NV - 2);

  logic [1:0]      state;
  logic [N_IN-1:0] vec_q;
  logic            busy_q;
  logic            done_q;
  logic            pass_q;
  logic [N_IN:0]   err_q;
  logic            fv_q;
  logic [N_IN-1:0] fidx_q;
  logic [NV-1:0]   obs_q;
  logic [NV-1:0]   exp_q;

  logic [CW-1:0]   cnt;
  logic            cnt_zero;
  logic            accept;
  logic            sample;
  logic            mismatch;
  logic            load;
  logic            enter_last;

  // done_q still high means we only just left SAMPLE_LAST; that start is dropped.
  assign accept   = (state == ST_IDLE) && bus.start && !done_q && !bus.abort;
  assign sample   = !bus.abort &&
                    (((state == ST_HOLD) && cnt_zero) || (state == ST_SAMPLE_LAST));
  assign mismatch = (bus.f != exp_q[vec_q]);
  assign load     = accept || (sample && (state == ST_HOLD));

  // SAMPLE_LAST is the final count==0 cycle of the last vector, so enter it one cycle early.
  assign enter_last = (SETTLE_CYC == 0) ? (cnt_zero && (vec_q == PRE_LAST))
                                        : ((vec_q == LAST_VEC) && (cnt == CW'(1)));

  settle_timer #(.W(CW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .load_val (CW'(SETTLE_CYC)),
    .value    (cnt),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      vec_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.abort) begin
        state  <= ST_IDLE;
        vec_q  <= '0;
        busy_q <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (accept) begin
              state  <= ST_HOLD;
              vec_q  <= '0;
              busy_q <= 1'b1;
            end
          end
          ST_HOLD: begin
            if (enter_last) state <= ST_SAMPLE_LAST;
            if (cnt_zero) vec_q <= vec_q + 1'b1;
          end
          ST_SAMPLE_LAST: begin
            state  <= ST_IDLE;
            vec_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_q <= 1'b0;
      err_q  <= '0;
      fv_q   <= 1'b0;
      fidx_q <= '0;
      obs_q  <= '0;
      exp_q  <= '0;
    end else if (accept) begin
      pass_q <= 1'b0;
      err_q  <= '0;
      fv_q   <= 1'b0;
      fidx_q <= '0;
      obs_q  <= '0;
      exp_q  <= bus.exp_tt;
    end else if (sample) begin
      obs_q[vec_q] <= bus.f;
      if (mismatch) begin
        err_q <= err_q + 1'b1;
        if (!fv_q) begin
          fv_q   <= 1'b1;
          fidx_q <= vec_q;
        end
      end
      if (state == ST_SAMPLE_LAST) pass_q <= (err_q == '0) && !mismatch;
    end
  end

  assign bus.vec        = vec_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.pass       = pass_q;
  assign bus.err_cnt    = err_q;
  assign bus.fail_valid = fv_q;
  assign bus.fail_idx   = fidx_q;
  assign bus.obs_tt     = obs_q;

endmodule

// File: tb/tb_tt_sweep_checker.sv
// tb/tb_tt_sweep_checker.sv - directed table and sequence bench for tt_sweep_checker
module tb_tt_sweep_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] exp_tt = 8'h00;
  logic       fault = 1'b0;
  logic       sel = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tt_sweep_checker_if #(.N_IN(3)) i0 ();
  tt_sweep_checker_if #(.N_IN(3)) i1 ();

  assign i0.start  = start && !sel;
  assign i1.start  = start && sel;
  assign i0.abort  = abort && !sel;
  assign i1.abort  = abort && sel;
  assign i0.exp_tt = exp_tt;
  assign i1.exp_tt = exp_tt;
  assign i0.f      = fault ? 1'b0 : ^i0.vec;
  assign i1.f      = fault ? 1'b0 : ^i1.vec;

  tt_sweep_checker #(.N_IN(3), .SETTLE_CYC(1)) u0 (.clk(clk), .rst_n(rst_n), .bus(i0));
  tt_sweep_checker #(.N_IN(3), .SETTLE_CYC(0)) u1 (.clk(clk), .rst_n(rst_n), .bus(i1));

  logic [2:0] o_vec;
  logic       o_busy, o_done, o_pass, o_fv;
  logic [3:0] o_err;
  logic [2:0] o_fidx;
  logic [7:0] o_obs;

  always_comb begin
    o_vec  = sel ? i1.vec        : i0.vec;
    o_busy = sel ? i1.busy       : i0.busy;
    o_done = sel ? i1.done       : i0.done;
    o_pass = sel ? i1.pass       : i0.pass;
    o_err  = sel ? i1.err_cnt    : i0.err_cnt;
    o_fv   = sel ? i1.fail_valid : i0.fail_valid;
    o_fidx = sel ? i1.fail_idx   : i0.fail_idx;
    o_obs  = sel ? i1.obs_tt     : i0.obs_tt;
  end

  typedef struct {
    logic       sel;
    logic       fault;
    logic [7:0] exp_tt;
    logic       pass;
    int         err;
    logic       fv;
    int         fidx;
    logic [7:0] obs;
    int         lat;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // Returns at the negedge after the edge where done first shows; lat = edges after start.
  task automatic run_sweep(output int lat, output int bad_vec);
    int s;
    s = sel ? 0 : 1;
    lat = -1;
    bad_vec = 0;
    pulse_start();
    for (int n = 0; n < 64; n++) begin
      if (n > 0) @(negedge clk);
      if (o_done) begin
        lat = n;
        break;
      end
      if (int'(o_vec) != (n / (s + 1)) % 8) bad_vec++;
    end
  endtask

  initial begin
    int lat, bad, dcnt, first_done;

    tbl[0] = '{1'b0, 1'b0, 8'h96, 1'b1, 0, 1'b0, 0, 8'h96, 16};
    tbl[1] = '{1'b0, 1'b1, 8'h96, 1'b0, 4, 1'b1, 1, 8'h00, 16};
    tbl[2] = '{1'b1, 1'b0, 8'h96, 1'b1, 0, 1'b0, 0, 8'h96, 8};
    tbl[3] = '{1'b0, 1'b0, 8'h00, 1'b0, 4, 1'b1, 1, 8'h96, 16};
    tbl[4] = '{1'b0, 1'b0, 8'hFF, 1'b0, 4, 1'b1, 0, 8'h96, 16};
    tbl[5] = '{1'b0, 1'b0, 8'h69, 1'b0, 8, 1'b1, 0, 8'h96, 16};
    tbl[6] = '{1'b1, 1'b1, 8'h00, 1'b1, 0, 1'b0, 0, 8'h00, 8};

    repeat (2) @(negedge clk);
    chk("reset_u0", int'({i0.vec, i0.busy, i0.done, i0.pass, i0.err_cnt, i0.fail_valid,
                          i0.fail_idx, i0.obs_tt}), 0);
    chk("reset_u1", int'({i1.vec, i1.busy, i1.done, i1.pass, i1.err_cnt, i1.fail_valid,
                          i1.fail_idx, i1.obs_tt}), 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      sel    = tbl[i].sel;
      fault  = tbl[i].fault;
      exp_tt = tbl[i].exp_tt;
      run_sweep(lat, bad);
      chk($sformatf("t%0d_latency", i), lat, tbl[i].lat);
      chk($sformatf("t%0d_vec_seq", i), bad, 0);
      chk($sformatf("t%0d_pass", i), int'(o_pass), int'(tbl[i].pass));
      chk($sformatf("t%0d_err_cnt", i), int'(o_err), tbl[i].err);
      chk($sformatf("t%0d_fail_valid", i), int'(o_fv), int'(tbl[i].fv));
      chk($sformatf("t%0d_fail_idx", i), int'(o_fidx), tbl[i].fidx);
      chk($sformatf("t%0d_obs_tt", i), int'(o_obs), int'(tbl[i].obs));
      @(negedge clk);
      chk($sformatf("t%0d_idle_after", i), int'({o_busy, o_done, o_vec}), 0);
    end

    // Starts at cycle 5 and coincident with done must both be dropped.
    sel = 1'b0; fault = 1'b1; exp_tt = 8'h96;
    dcnt = 0; first_done = -1;
    pulse_start();
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (n == 4) start = 1'b1;
      if (o_done) begin
        dcnt++;
        if (first_done < 0) begin
          first_done = n;
          start = 1'b1;
        end
      end
    end
    start = 1'b0;
    chk("ign_done_count", dcnt, 1);
    chk("ign_done_time", first_done, 16);
    chk("ign_busy_after", int'(o_busy), 0);
    chk("ign_err_held", int'(o_err), 4);

    fault = 1'b0;
    pulse_start();
    chk("fresh_cleared", int'({o_err, o_fv, o_obs, o_pass}), 0);
    chk("fresh_busy", int'(o_busy), 1);
    dcnt = 0;
    for (int n = 1; n <= 30 && !o_done; n++) @(negedge clk);
    chk("fresh_done", int'(o_done), 1);
    chk("fresh_pass", int'(o_pass), 1);
    chk("fresh_obs", int'(o_obs), 8'h96);
    @(negedge clk);

    // Abort sampled at edge 7: vectors 0..2 sampled, 1 and 2 mismatch.
    fault = 1'b1;
    pulse_start();
    repeat (6) @(negedge clk);
    abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    chk("abort_busy", int'(o_busy), 0);
    chk("abort_vec", int'(o_vec), 0);
    chk("abort_err", int'(o_err), 2);
    chk("abort_fail", int'({o_fv, o_fidx}), 4'b1001);
    chk("abort_pass", int'(o_pass), 0);
    chk("abort_obs", int'(o_obs), 0);
    dcnt = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (o_done) dcnt++;
    end
    chk("abort_no_done", dcnt, 0);
    chk("abort_err_held", int'(o_err), 2);

    // Asynchronous reset mid-sweep.
    fault = 1'b0;
    pulse_start();
    repeat (6) @(negedge clk);
    chk("rst_pre_busy", int'(o_busy), 1);
    rst_n = 1'b0;
    #1;
    chk("rst_immediate", int'({o_vec, o_busy, o_done, o_pass, o_err, o_fv, o_fidx, o_obs}), 0);
    @(negedge clk) rst_n = 1'b1;
    dcnt = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (o_done || o_busy) dcnt++;
    end
    chk("rst_stays_idle", dcnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
